ro_pair_sel_cmp: RTL and testbench
==================================

Name: ro_pair_sel_cmp

Overview:
- Parametrised successor to the fixed 16:1 oscillator mux.
- Selects two of NUM_RO ring-oscillator outputs through independent N:1 muxes, synchronises both into the clk domain, and counts their rising edges over a programmable window of clk cycles.
- Emits one PUF response bit per challenge (sel_a, sel_b) with a start/done handshake.
- Sits between the RO array and the PUF response collector.

Parameters:
- NUM_RO, 16, number of ring-oscillator inputs (2..256; need not be a power of 2).
- SEL_W, $clog2(NUM_RO), width of each select input.
- CNT_W, 16, width of the edge counters (saturating).
- WIN_W, 16, width of the measurement-window length.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous, active-low reset.
- ro_in  input  NUM_RO  raw ring-oscillator outputs, asynchronous to clk.
- sel_a  input  SEL_W  challenge index A.
- sel_b  input  SEL_W  challenge index B.
- window  input  WIN_W  count window length in clk cycles.
- start  input  1  request measurement; sampled only in IDLE.
- busy  output  1  high from the accepted start until done.
- done  output  1  one-cycle pulse when results are valid.
- resp  output  1  response bit: 1 iff cnt_a > cnt_b.
- cnt_a  output  CNT_W  edge count for oscillator A.
- cnt_b  output  CNT_W  edge count for oscillator B.
- sel_err  output  1  set with done when the challenge was illegal.

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous and active-low. All state, including the synchroniser flops, resets on a rising clk edge while rst_n=0.
- Reset values: busy=0, done=0, resp=0, sel_err=0, cnt_a=0, cnt_b=0, FSM=IDLE.
- Asserting rst_n=0 mid-measurement aborts it; no done pulse is produced.
- Mux: combinational ro_in[sel_a_q] and ro_in[sel_b_q], using the selects latched at start. Each output then passes through a 2-flop synchroniser plus a history flop. Rising edge = s2 & ~s3.
- FSM states: IDLE, SETTLE, COUNT, FINISH.
- IDLE:
  - start=1 latches sel_a, sel_b and window.
  - If sel_a==sel_b, or either select is >= NUM_RO: go to FINISH with sel_err=1 and counts cleared to 0.
  - Otherwise: clear counts, busy=1, go to SETTLE.
- SETTLE: exactly 3 cycles to flush the synchronisers. Edges are not counted. Then:
  - window_q==0 -> FINISH (counts stay 0).
  - window_q!=0 -> COUNT.
- COUNT:
  - Runs exactly window_q cycles, using a down-counter loaded from window_q.
  - Each cycle, each counter increments on its detected edge.
  - Counters saturate at 2^CNT_W-1 and never wrap.
  - After the final counting cycle, go to FINISH.
- FINISH (1 cycle): done=1, resp=(cnt_a>cnt_b), busy=0, then return to IDLE.
- Tie (cnt_a==cnt_b), window 0, or sel_err: resp=0.
- Output hold: resp, cnt_a, cnt_b and sel_err hold until the next accepted start. At that start they are cleared in the same cycle.
- Latency (legal challenge): start at cycle T -> done at T+1+3+window. Example: window=100 -> done at T+104.
- Illegal challenge: done at T+1.
- start while busy: ignored; no queuing.
- start in the FINISH cycle: ignored.
- start in the cycle after done: accepted.
- Inputs sel_a, sel_b and window may change freely while busy; only the latched copies are used.
- Frequency limit: each RO frequency must be < clk/2 for exact counts. Faster oscillators undercount and are not detected.

Optional Feature:
- Macro: RO_TIE_FLAG_EN.
- Defined: adds output port tie (1 bit, reset 0), set in FINISH when cnt_a==cnt_b and sel_err=0. tie holds with the other results and is cleared at the next accepted start. The collector can then discard unstable bits.
- Undefined: no tie port; ties are reported only as resp=0.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with start=1 -> busy=0, done=0, resp=0, cnt_a=cnt_b=0, no FSM progress.
- Legal compare: ro_in[3] toggles every 4 clk and ro_in[9] every 6 clk; sel_a=3, sel_b=9, window=96, start at T:
  - done at T+100, resp=1, busy=0 after done.
  - cnt_a=12 and cnt_b=8, each within ±1.
- Swapped challenge: same stimulus with sel_a=9, sel_b=3 -> resp=0, cnt_a≈8, cnt_b≈12.
- Illegal select:
  - sel_a=sel_b=5 -> done at T+1, sel_err=1, resp=0, counts 0.
  - With NUM_RO=12: sel_a=13 -> same result.
- Boundaries:
  - window=0 -> done at T+4, counts 0, resp=0.
  - CNT_W=4 with window=200 on a fast RO -> cnt saturates at 15.
  - start pulsed during COUNT -> ignored, single done.
- Reset mid-COUNT: rst_n=0 at T+50 of a window=96 run -> no done, outputs 0. A new start after release completes normally. With RO_TIE_FLAG_EN, equal ROs -> tie=1, resp=0.

Source files
------------

// File: rtl/ro_pair_sel_cmp.sv
//----------------------------------------------------------------------------
// Module      : ro_pair_sel_cmp
// Description : Pair-select ring-oscillator comparator; counts synchronised
//               rising edges of two selected ROs over a window and emits a
//               PUF response bit. Optional macro RO_TIE_FLAG_EN adds 'tie'.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module ro_pair_sel_cmp #(
  parameter int NUM_RO = 16,
  parameter int SEL_W  = $clog2(NUM_RO),
  parameter int CNT_W  = 16,
  parameter int WIN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_RO-1:0] ro_in,
  input  logic [SEL_W-1:0]  sel_a,
  input  logic [SEL_W-1:0]  sel_b,
  input  logic [WIN_W-1:0]  window,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              resp,
  output logic [CNT_W-1:0]  cnt_a,
  output logic [CNT_W-1:0]  cnt_b,
`ifdef RO_TIE_FLAG_EN
  output logic              tie,
`endif
  output logic              sel_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    COUNT  = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_illegal;
  logic [SEL_W-1:0] r_sel_a;
  logic [SEL_W-1:0] r_sel_b;
  logic [WIN_W-1:0] r_win;
  logic [1:0]       r_settle;
  logic [2:0]       r_sync_a;
  logic [2:0]       r_sync_b;
  logic             w_mux_a;
  logic             w_mux_b;
  logic             w_edge_a;
  logic             w_edge_b;
  logic [CNT_W-1:0] r_cnt_a;
  logic [CNT_W-1:0] r_cnt_b;
  logic [CNT_W-1:0] w_cnt_a_nxt;
  logic [CNT_W-1:0] w_cnt_b_nxt;
  logic             r_resp;
  logic             r_sel_err;
  logic             r_tie;

  // Range check widened to 32 bits so NUM_RO == 2**SEL_W stays representable
  assign w_illegal = (sel_a == sel_b) ||
                     (32'(sel_a) >= NUM_RO) ||
                     (32'(sel_b) >= NUM_RO);

  always_comb begin
    w_mux_a = 1'b0;
    w_mux_b = 1'b0;
    for (int i = 0; i < NUM_RO; i++) begin
      if (r_sel_a == SEL_W'(i)) w_mux_a = ro_in[i];
      if (r_sel_b == SEL_W'(i)) w_mux_b = ro_in[i];
    end
  end

  assign w_edge_a = r_sync_a[1] & ~r_sync_a[2];
  assign w_edge_b = r_sync_b[1] & ~r_sync_b[2];

  assign w_cnt_a_nxt = (w_edge_a && (r_cnt_a != c_cnt_max)) ? r_cnt_a + CNT_W'(1) : r_cnt_a;
  assign w_cnt_b_nxt = (w_edge_b && (r_cnt_b != c_cnt_max)) ? r_cnt_b + CNT_W'(1) : r_cnt_b;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = w_illegal ? FINISH : SETTLE;
        end
      end
      SETTLE: begin
        busy = 1'b1;
        if (r_settle == 2'd2) w_state_nxt = (r_win == '0) ? FINISH : COUNT;
      end
      COUNT: begin
        busy = 1'b1;
        if (r_win == WIN_W'(1)) w_state_nxt = FINISH;
      end
      FINISH: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sel_a   <= '0;
      r_sel_b   <= '0;
      r_win     <= '0;
      r_settle  <= '0;
      r_sync_a  <= '0;
      r_sync_b  <= '0;
      r_cnt_a   <= '0;
      r_cnt_b   <= '0;
      r_resp    <= 1'b0;
      r_sel_err <= 1'b0;
      r_tie     <= 1'b0;
    end else begin
      r_sync_a <= {r_sync_a[1:0], w_mux_a};
      r_sync_b <= {r_sync_b[1:0], w_mux_b};
      if (w_accept) begin
        r_sel_a   <= sel_a;
        r_sel_b   <= sel_b;
        r_win     <= window;
        r_settle  <= '0;
        r_cnt_a   <= '0;
        r_cnt_b   <= '0;
        r_resp    <= 1'b0;
        r_tie     <= 1'b0;
        r_sel_err <= w_illegal;
      end else if (r_state == SETTLE) begin
        r_settle <= r_settle + 2'd1;
        // Zero window still reports a legal tie of 0 vs 0
        if ((r_settle == 2'd2) && (r_win == '0)) r_tie <= 1'b1;
      end else if (r_state == COUNT) begin
        r_win   <= r_win - WIN_W'(1);
        r_cnt_a <= w_cnt_a_nxt;
        r_cnt_b <= w_cnt_b_nxt;
        r_resp  <= (w_cnt_a_nxt > w_cnt_b_nxt);
        r_tie   <= (w_cnt_a_nxt == w_cnt_b_nxt);
      end
    end
  end

  assign resp    = r_resp;
  assign cnt_a   = r_cnt_a;
  assign cnt_b   = r_cnt_b;
  assign sel_err = r_sel_err;

`ifdef RO_TIE_FLAG_EN
  assign tie = r_tie;
`else
  logic w_unused;
  assign w_unused = r_tie;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ro_pair_sel_cmp.sv
//----------------------------------------------------------------------------
// Module      : tb_ro_pair_sel_cmp
// Description : Directed self-checking bench for ro_pair_sel_cmp.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_ro_pair_sel_cmp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] ro_in = '0;
  logic [3:0]  sel_a;
  logic [3:0]  sel_b;
  logic [15:0] window;

  logic        busy, done, resp, sel_err;
  logic [15:0] cnt_a, cnt_b;
  logic        busy2, done2, resp2, sel_err2;
  logic [3:0]  cnt_a2, cnt_b2;
`ifdef RO_TIE_FLAG_EN
  logic        tie, tie2;
`endif

  int checks   = 0;
  int failures = 0;
  int tick     = 0;

  always #5 clk = ~clk;

  ro_pair_sel_cmp dut (
    .clk(clk), .rst_n(rst_n), .ro_in(ro_in), .sel_a(sel_a), .sel_b(sel_b),
    .window(window), .start(start), .busy(busy), .done(done), .resp(resp),
    .cnt_a(cnt_a), .cnt_b(cnt_b),
`ifdef RO_TIE_FLAG_EN
    .tie(tie),
`endif
    .sel_err(sel_err)
  );

  // Non-power-of-two array with narrow saturating counters
  ro_pair_sel_cmp #(.NUM_RO(12), .CNT_W(4), .WIN_W(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .ro_in(ro_in[11:0]), .sel_a(sel_a), .sel_b(sel_b),
    .window(window), .start(start), .busy(busy2), .done(done2), .resp(resp2),
    .cnt_a(cnt_a2), .cnt_b(cnt_b2),
`ifdef RO_TIE_FLAG_EN
    .tie(tie2),
`endif
    .sel_err(sel_err2)
  );

  // RO models: [1] period 4, [3]/[4] period 8, [9] period 12 clk cycles
  always @(negedge clk) begin
    tick     = tick + 1;
    ro_in[1] = ((tick / 2) % 2) == 1;
    ro_in[3] = ((tick / 4) % 2) == 1;
    ro_in[4] = ((tick / 4) % 2) == 1;
    ro_in[9] = ((tick / 6) % 2) == 1;
  end

  task automatic check(input string tag, input longint got, input longint exp, input longint tol);
    checks++;
    if (got < exp - tol || got > exp + tol) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch one challenge; returns cycles from start sample to done (bounded)
  task automatic run(input logic [3:0] a, input logic [3:0] b, input logic [15:0] w,
                     output int lat);
    sel_a = a;
    sel_b = b;
    window = w;
    start = 1'b1;
    step();
    start = 1'b0;
    lat = 1;
    while (!done && lat < 1000) begin
      step();
      lat++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int ndone;

    rst_n = 1'b0;
    start = 1'b1;
    sel_a = 4'd3;
    sel_b = 4'd9;
    window = 16'd96;
    step();
    step();
    check("rst_busy", busy, 0, 0);
    check("rst_done", done, 0, 0);
    check("rst_resp", resp, 0, 0);
    check("rst_cnt_a", cnt_a, 0, 0);
    check("rst_cnt_b", cnt_b, 0, 0);
    check("rst_sel_err", sel_err, 0, 0);
    rst_n = 1'b1;
    start = 1'b0;
    step();
    check("rst_idle_busy", busy, 0, 0);

    // Legal compare A=3 (12 edges), B=9 (8 edges)
    run(4'd3, 4'd9, 16'd96, lat);
    check("legal_lat", lat, 100, 0);
    check("legal_resp", resp, 1, 0);
    check("legal_cnt_a", cnt_a, 12, 1);
    check("legal_cnt_b", cnt_b, 8, 1);
    check("legal_sel_err", sel_err, 0, 0);
    check("legal_busy_done", busy, 0, 0);
`ifdef RO_TIE_FLAG_EN
    check("legal_tie", tie, 0, 0);
`endif
    step();
    check("hold_done", done, 0, 0);
    check("hold_resp", resp, 1, 0);
    check("hold_cnt_a", cnt_a, 12, 1);

    // Swapped challenge
    run(4'd9, 4'd3, 16'd96, lat);
    check("swap_lat", lat, 100, 0);
    check("swap_resp", resp, 0, 0);
    check("swap_cnt_a", cnt_a, 8, 1);
    check("swap_cnt_b", cnt_b, 12, 1);
    step();

    // Equal selects are illegal
    run(4'd5, 4'd5, 16'd96, lat);
    check("eq_lat", lat, 1, 0);
    check("eq_sel_err", sel_err, 1, 0);
    check("eq_resp", resp, 0, 0);
    check("eq_cnt_a", cnt_a, 0, 0);
    check("eq_cnt_b", cnt_b, 0, 0);
    step();

    // Zero window
    run(4'd3, 4'd9, 16'd0, lat);
    check("w0_lat", lat, 4, 0);
    check("w0_cnt_a", cnt_a, 0, 0);
    check("w0_cnt_b", cnt_b, 0, 0);
    check("w0_resp", resp, 0, 0);
    check("w0_sel_err", sel_err, 0, 0);
`ifdef RO_TIE_FLAG_EN
    check("w0_tie", tie, 1, 0);
`endif
    step();

    // Out-of-range select on the 12-input instance
    sel_a = 4'd13;
    sel_b = 4'd2;
    window = 16'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("oor_done", done2, 1, 0);
    check("oor_sel_err", sel_err2, 1, 0);
    check("oor_resp", resp2, 0, 0);
    check("oor_cnt_a", cnt_a2, 0, 0);
    check("oor_wide_sel_err", sel_err, 0, 0);
    repeat (6) step();

    // Saturation: fast RO over 200 cycles into 4-bit counters
    run(4'd1, 4'd9, 16'd200, lat);
    check("sat_lat", lat, 204, 0);
    check("sat_done2", done2, 1, 0);
    check("sat_cnt_a2", cnt_a2, 15, 0);
    check("sat_cnt_b2", cnt_b2, 15, 0);
    check("sat_resp2", resp2, 0, 0);
    check("sat_cnt_a_wide", cnt_a, 50, 1);
    step();

    // start pulsed mid-COUNT with an illegal challenge: ignored
    sel_a = 4'd3;
    sel_b = 4'd9;
    window = 16'd96;
    start = 1'b1;
    step();
    start = 1'b0;
    ndone = 0;
    for (int i = 1; i < 130; i++) begin
      if (i == 10) check("mid_busy", busy, 1, 0);
      if (i == 30) begin
        sel_a = 4'd5;
        sel_b = 4'd5;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) ndone++;
      step();
    end
    check("mid_ndone", ndone, 1, 0);
    check("mid_resp", resp, 1, 0);
    check("mid_cnt_a", cnt_a, 12, 1);
    check("mid_sel_err", sel_err, 0, 0);

    // Reset mid-COUNT aborts without done
    sel_a = 4'd3;
    sel_b = 4'd9;
    window = 16'd96;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (49) step();
    rst_n = 1'b0;
    step();
    step();
    check("abort_busy", busy, 0, 0);
    check("abort_done", done, 0, 0);
    check("abort_cnt_a", cnt_a, 0, 0);
    check("abort_resp", resp, 0, 0);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 60; i++) begin
      if (done) ndone++;
      step();
    end
    check("abort_ndone", ndone, 0, 0);
    run(4'd3, 4'd9, 16'd96, lat);
    check("after_lat", lat, 100, 0);
    check("after_resp", resp, 1, 0);
    step();

`ifdef RO_TIE_FLAG_EN
    run(4'd3, 4'd4, 16'd96, lat);
    check("tie_flag", tie, 1, 0);
    check("tie_resp", resp, 0, 0);
    check("tie_cnt_a", cnt_a, 12, 1);
    check("tie_cnt_b", cnt_b, 12, 1);
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
